// File: rtl/lerp_arbiter.sv
// lerp_arbiter: round-robin front end that shares one lerp engine among N
// requesters. The winner's operands are latched at grant. One engine operation
// runs at a time, and the result returns with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req[N]                       per-requester request level
//   req_x1/x2/y1/y2/x[N*S]       packed operands, requester i at [i*S +: S]
//   gnt[N]                       one-hot grant, held from acceptance to end of RESP
//   done[N]                      one-cycle completion pulse to the granted requester
//   y[S]                         result register, broadcast to all requesters
//   busy                         high whenever the FSM is not in IDLE
//   err                          watchdog timeout flag, qualified by done
//   eng_start                    one-cycle start pulse to the engine
//   eng_x1/x2/y1/y2/x[S]         latched operand registers driving the engine
//   eng_y[S], eng_done           engine result and done (level or pulse)
//
// Optional feature: define LERP_ARB_TIMEOUT_EN to enable a WAIT watchdog of
// TIMEOUT cycles. On expiry y becomes quiet NaN and err is raised. Without the
// macro, WAIT has no limit and err is constant 0.
module lerp_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned S       = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*S-1:0] req_x1,
    input  logic [N*S-1:0] req_x2,
    input  logic [N*S-1:0] req_y1,
    input  logic [N*S-1:0] req_y2,
    input  logic [N*S-1:0] req_x,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [S-1:0]   y,
    output logic           busy,
    output logic           err,
    output logic           eng_start,
    output logic [S-1:0]   eng_x1,
    output logic [S-1:0]   eng_x2,
    output logic [S-1:0]   eng_y1,
    output logic [S-1:0]   eng_y2,
    output logic [S-1:0]   eng_x,
    input  logic [S-1:0]   eng_y,
    input  logic           eng_done
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  gnt_d, done_d;
    logic [S-1:0]  y_d;
    logic          err_d, start_d;
    logic [S-1:0]  x1_d, x2_d, y1_d, y2_d, x_d;
    logic          eng_done_q;
    logic          complete_c;
    logic          found;
    logic [PW-1:0] win;

    // Only a rising edge of eng_done completes an op, so a stale level is ignored.
    assign complete_c = eng_done & ~eng_done_q;

`ifdef LERP_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Round-robin search starting just after the last winner.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt;
        done_d  = '0;
        y_d     = y;
        err_d   = err;
        start_d = 1'b0;
        x1_d    = eng_x1;
        x2_d    = eng_x2;
        y1_d    = eng_y1;
        y2_d    = eng_y2;
        x_d     = eng_x;
`ifdef LERP_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d = ISSUE;
                    ptr_d   = win;
                    gnt_d   = N'(1) << win;
                    err_d   = 1'b0;
                    start_d = 1'b1;
                    x1_d    = req_x1[32'(win)*S +: S];
                    x2_d    = req_x2[32'(win)*S +: S];
                    y1_d    = req_y1[32'(win)*S +: S];
                    y2_d    = req_y2[32'(win)*S +: S];
                    x_d     = req_x[32'(win)*S +: S];
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef LERP_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (complete_c) begin
                    y_d     = eng_y;
                    done_d  = gnt;
                    state_d = RESP;
                end
`ifdef LERP_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    y_d     = S'(32'h7FC0_0000);
                    err_d   = 1'b1;
                    done_d  = gnt;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= PW'(N - 1);
            gnt        <= '0;
            done       <= '0;
            y          <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            eng_start  <= 1'b0;
            eng_x1     <= '0;
            eng_x2     <= '0;
            eng_y1     <= '0;
            eng_y2     <= '0;
            eng_x      <= '0;
            eng_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt        <= gnt_d;
            done       <= done_d;
            y          <= y_d;
            busy       <= (state_d != IDLE);
            err        <= err_d;
            eng_start  <= start_d;
            eng_x1     <= x1_d;
            eng_x2     <= x2_d;
            eng_y1     <= y1_d;
            eng_y2     <= y2_d;
            eng_x      <= x_d;
            eng_done_q <= eng_done;
        end
    end

`ifdef LERP_ARB_TIMEOUT_EN
    // WAIT-cycle watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_lerp_arbiter.sv
// Self-checking bench for lerp_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a cycle-level reference model.
module tb_lerp_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned S  = 32;
    localparam int unsigned TO = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [N*S-1:0] req_x1, req_x2, req_y1, req_y2, req_x;
    logic [N-1:0]   gnt, done;
    logic [S-1:0]   y;
    logic           busy, err, eng_start;
    logic [S-1:0]   eng_x1, eng_x2, eng_y1, eng_y2, eng_x;
    logic [S-1:0]   eng_y;
    logic           eng_done;

    int n_pass = 0;
    int n_tot  = 0;
    int eng_mode = 0;   // 0: done pulse, 1: done level held, 2: never done

    always #5 clk = ~clk;

    lerp_arbiter #(.N(N), .S(S), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .req_x1(req_x1), .req_x2(req_x2), .req_y1(req_y1), .req_y2(req_y2), .req_x(req_x),
        .gnt(gnt), .done(done), .y(y), .busy(busy), .err(err), .eng_start(eng_start),
        .eng_x1(eng_x1), .eng_x2(eng_x2), .eng_y1(eng_y1), .eng_y2(eng_y2), .eng_x(eng_x),
        .eng_y(eng_y), .eng_done(eng_done)
    );

    // Float helpers for non-negative integer-valued singles.
    function automatic logic [31:0] i2f(input int v);
        int p;
        logic [31:0] sh;
        if (v <= 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 31; b++) if (v[b]) p = b;
        sh = 32'(v) << (23 - p);
        return {1'b0, 8'(127 + p), sh[22:0]};
    endfunction

    function automatic int f2i(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'h0, 1'b1, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [31:0] lerp_f(input logic [31:0] a, b, c, d, e);
        int x1, x2, y1, y2, x;
        x1 = f2i(a); x2 = f2i(b); y1 = f2i(c); y2 = f2i(d); x = f2i(e);
        if (x2 == x1) return c;
        return i2f(y1 + (x - x1) * (y2 - y1) / (x2 - x1));
    endfunction

    // Engine model: 5-cycle latency, computes on the operands present at start.
    int          e_cnt;
    logic [31:0] e_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt <= 0; eng_done <= 1'b0; eng_y <= '0; e_res <= '0;
        end else if (eng_start) begin
            e_cnt <= 5;
            e_res <= lerp_f(eng_x1, eng_x2, eng_y1, eng_y2, eng_x);
            if (eng_mode == 0) eng_done <= 1'b0;
        end else if (e_cnt != 0) begin
            e_cnt <= e_cnt - 1;
            if (eng_mode == 1 && e_cnt == 2) eng_done <= 1'b0;
            if (eng_mode != 2 && e_cnt == 1) begin
                eng_done <= 1'b1;
                eng_y    <= e_res;
            end
        end else if (eng_mode == 0) begin
            eng_done <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, b, c, d, e);
        req_x1[i*S +: S] = a; req_x2[i*S +: S] = b; req_y1[i*S +: S] = c;
        req_y2[i*S +: S] = d; req_x[i*S +: S]  = e;
    endtask

    task automatic wait_done(input int lim, output bit got, output int cyc, output int starts);
        got = 1'b0; cyc = 0; starts = 0;
        while (!got && cyc < lim) begin
            tick();
            cyc++;
            if (eng_start) starts++;
            if (done != '0) got = 1'b1;
        end
    endtask

    typedef struct {
        logic [N-1:0] rq;
        logic [31:0]  x1, x2, y1, y2, x;
        logic [N-1:0] g;
        logic [31:0]  ey;
    } vec_t;

    vec_t vt[13];

    task automatic run_vec(input vec_t v, input int idx);
        bit got; int cyc, starts;
        string t;
        t = $sformatf("vec%0d", idx);
        req = v.rq;
        for (int i = 0; i < N; i++) set_ops(i, v.x1, v.x2, v.y1, v.y2, v.x);
        tick();
        chk({t, " gnt"}, 32'(gnt), 32'(v.g));
        chk({t, " start"}, 32'(eng_start), 32'd1);
        chk({t, " busy"}, 32'(busy), 32'd1);
        wait_done(60, got, cyc, starts);
        chk({t, " done_seen"}, 32'(got), 32'd1);
        chk({t, " done"}, 32'(done), 32'(v.g));
        chk({t, " y"}, y, v.ey);
        chk({t, " gnt_hold"}, 32'(gnt), 32'(v.g));
        chk({t, " err"}, 32'(err), 32'd0);
        chk({t, " extra_start"}, 32'(starts), 32'd0);
        req = '0;
        tick();
        chk({t, " idle_gnt"}, 32'(gnt), 32'd0);
        chk({t, " idle_done"}, 32'(done), 32'd0);
        chk({t, " idle_busy"}, 32'(busy), 32'd0);
        chk({t, " y_hold"}, y, v.ey);
    endtask

    task automatic gen_ops(output logic [31:0] a, b, c, d, e);
        int x1, dd, y1, m, j;
        x1 = int'($urandom_range(0, 3));
        dd = 1 << $urandom_range(0, 2);
        y1 = int'($urandom_range(0, 7));
        m  = int'($urandom_range(0, 3));
        j  = int'($urandom_range(0, dd));
        a = i2f(x1); b = i2f(x1 + dd); c = i2f(y1); d = i2f(y1 + dd * m); e = i2f(x1 + j);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_pass %0d", n_pass);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got; int cyc, starts, cnt;
        logic [31:0] a, b, c, d, e;
        // random-phase model state
        int          rs[N];
        int          m_ph, m_last, m_w;
        logic [N-1:0] m_gnt, rq, exp_done;
        logic [31:0] m_y, m_ey;
        logic        ed_now, ed_prev, exp_es;

        vt[0]  = '{4'b0001, 32'h0, 32'h40000000, 32'h3F800000, 32'h40400000, 32'h3F800000, 4'b0001, 32'h40000000};
        vt[1]  = '{4'b0010, 32'h0, 32'h40800000, 32'h0, 32'h41000000, 32'h40400000, 4'b0010, 32'h40C00000};
        vt[2]  = '{4'b0100, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h40C00000, 32'h40000000, 4'b0100, 32'h40800000};
        vt[3]  = '{4'b1000, 32'h0, 32'h3F800000, 32'h40A00000, 32'h40A00000, 32'h3F800000, 4'b1000, 32'h40A00000};
        vt[4]  = '{4'b0110, 32'h0, 32'h40000000, 32'h3F800000, 32'h40400000, 32'h3F800000, 4'b0010, 32'h40000000};
        vt[5]  = '{4'b0110, 32'h0, 32'h40800000, 32'h0, 32'h41000000, 32'h40400000, 4'b0100, 32'h40C00000};
        vt[6]  = '{4'b1001, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h40C00000, 32'h40000000, 4'b1000, 32'h40800000};
        vt[7]  = '{4'b1111, 32'h0, 32'h3F800000, 32'h40A00000, 32'h40A00000, 32'h3F800000, 4'b0001, 32'h40A00000};
        vt[8]  = '{4'b1111, 32'h0, 32'h40000000, 32'h3F800000, 32'h40400000, 32'h3F800000, 4'b0010, 32'h40000000};
        vt[9]  = '{4'b1111, 32'h0, 32'h40800000, 32'h0, 32'h41000000, 32'h40400000, 4'b0100, 32'h40C00000};
        vt[10] = '{4'b1111, 32'h3F800000, 32'h40400000, 32'h40000000, 32'h40C00000, 32'h40000000, 4'b1000, 32'h40800000};
        vt[11] = '{4'b1111, 32'h0, 32'h3F800000, 32'h40A00000, 32'h40A00000, 32'h3F800000, 4'b0001, 32'h40A00000};
        vt[12] = '{4'b0001, 32'h0, 32'h40000000, 32'h3F800000, 32'h40400000, 32'h3F800000, 4'b0001, 32'h40000000};

        req = '0; req_x1 = '0; req_x2 = '0; req_y1 = '0; req_y2 = '0; req_x = '0;
        rst_n = 1'b0;
        tick(); tick();
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst y", y, 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst start", 32'(eng_start), 32'd0);
        chk("rst eng_x", eng_x, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) run_vec(vt[i], i);

        // Operands and req change after grant must not affect the op in flight.
        req = 4'b0100;
        for (int i = 0; i < N; i++) set_ops(i, vt[2].x1, vt[2].x2, vt[2].y1, vt[2].y2, vt[2].x);
        tick();
        chk("iso gnt", 32'(gnt), 32'b0100);
        set_ops(2, vt[2].x1, vt[2].x2, vt[2].y1, vt[2].y2, 32'h40C00000);
        req = '0;
        wait_done(60, got, cyc, starts);
        chk("iso done", 32'(done), 32'b0100);
        chk("iso y", y, 32'h40800000);
        tick();

        // Reset during WAIT aborts; pointer restarts at requester 0.
        req = 4'b0010;
        for (int i = 0; i < N; i++) set_ops(i, vt[0].x1, vt[0].x2, vt[0].y1, vt[0].y2, vt[0].x);
        tick();
        chk("rstw gnt", 32'(gnt), 32'b0010);
        tick(); tick();
        chk("rstw busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0; req = '0;
        #1;
        chk("rstw gnt", 32'(gnt), 32'd0);
        chk("rstw done", 32'(done), 32'd0);
        chk("rstw busy", 32'(busy), 32'd0);
        chk("rstw y", y, 32'd0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done != '0 || eng_start) cnt++;
        end
        chk("rstw no_done", 32'(cnt), 32'd0);
        req = 4'b1111;
        tick();
        chk("rstw first_gnt", 32'(gnt), 32'b0001);
        wait_done(60, got, cyc, starts);
        chk("rstw y_after", y, 32'h40000000);
        req = '0;
        tick();

`ifdef LERP_ARB_TIMEOUT_EN
        // Engine never completes: watchdog fires after TO WAIT cycles.
        eng_mode = 2;
        req = 4'b0001;
        tick();
        chk("to gnt", 32'(gnt), 32'b0001);
        wait_done(60, got, cyc, starts);
        chk("to latency", 32'(cyc), 32'(TO + 1));
        chk("to done", 32'(done), 32'b0001);
        chk("to y", y, 32'h7FC00000);
        chk("to err", 32'(err), 32'd1);
        req = '0; eng_mode = 0;
        tick();
        chk("to err_hold", 32'(err), 32'd1);
        req = 4'b0010;
        for (int i = 0; i < N; i++) set_ops(i, vt[1].x1, vt[1].x2, vt[1].y1, vt[1].y2, vt[1].x);
        tick();
        chk("to err_clr", 32'(err), 32'd0);
        wait_done(60, got, cyc, starts);
        chk("to y_next", y, 32'h40C00000);
        req = '0;
        tick();
`endif

        // Randomized run against the reference model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) rs[i] = 0;
        m_ph = 0; m_last = N - 1; m_w = 0; m_gnt = '0; m_y = '0; m_ey = '0;
        ed_prev = eng_done;
        for (int cyc_i = 0; cyc_i < 800; cyc_i++) begin
            if (cyc_i >= 400 && m_ph == 0) eng_mode = 1;
            rq = req;
            ed_now = eng_done;
            tick();
            exp_done = '0;
            exp_es = 1'b0;
            case (m_ph)
                0: if (rq != '0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (rq[(m_last + k) % N]) begin
                            m_w = (m_last + k) % N;
                            break;
                        end
                    end
                    m_last = m_w;
                    m_gnt = N'(1) << m_w;
                    m_ey = lerp_f(req_x1[m_w*S +: S], req_x2[m_w*S +: S], req_y1[m_w*S +: S],
                                  req_y2[m_w*S +: S], req_x[m_w*S +: S]);
                    exp_es = 1'b1;
                    m_ph = 1;
                end
                1: m_ph = 2;
                2: if (ed_now && !ed_prev) begin
                    m_y = m_ey;
                    exp_done = m_gnt;
                    m_ph = 3;
                end
                default: begin
                    m_gnt = '0;
                    m_ph = 0;
                end
            endcase
            ed_prev = ed_now;
            chk("rnd gnt", 32'(gnt), 32'(m_gnt));
            chk("rnd done", 32'(done), 32'(exp_done));
            chk("rnd start", 32'(eng_start), 32'(exp_es));
            chk("rnd busy", 32'(busy), (m_ph != 0) ? 32'd1 : 32'd0);
            chk("rnd y", y, m_y);
            if (exp_done != '0) begin
                rs[m_w] = 0;
                req[m_w] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (rs[i] == 0 && !(exp_done != '0 && i == m_w) && $urandom_range(0, 2) == 0) begin
                    gen_ops(a, b, c, d, e);
                    set_ops(i, a, b, c, d, e);
                    req[i] = 1'b1;
                    rs[i] = 1;
                end
            end
            if ((m_ph == 1 || m_ph == 2) && rs[m_w] == 1) begin
                if ($urandom_range(0, 7) == 0) begin
                    gen_ops(a, b, c, d, e);
                    set_ops(m_w, a, b, c, d, e);
                end
                if ($urandom_range(0, 9) == 0) begin
                    req[m_w] = 1'b0;
                    rs[m_w] = 2;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/lerp_arbiter.md
Name: lerp_arbiter

Overview:
- Shares one lerp engine (five float operands in, one float result out, start/done handshake) among N requesters, e.g. the neuron-activation units.
- Arbitrates round-robin and latches the winner's operands.
- Sequences a single engine operation, then returns the result with a one-cycle done pulse to the winner.
- Sits between the activation requesters and the single lerp instance.

Parameters:
N, 4, number of requesters (2..8)
S, 32, float width in bits
TIMEOUT, 255, watchdog limit in cycles; used only with LERP_ARB_TIMEOUT_EN

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N  per-requester request level
req_x1  in  N*S  packed x1 operands; requester i at bits [i*S +: S]
req_x2  in  N*S  packed x2 operands
req_y1  in  N*S  packed y1 operands
req_y2  in  N*S  packed y2 operands
req_x  in  N*S  packed x operands
gnt  out  N  one-hot grant, held from acceptance to the end of RESP
done  out  N  one-cycle completion pulse to the granted requester
y  out  S  result register, broadcast to all requesters
busy  out  1  high in any state other than IDLE
err  out  1  timeout flag, qualified by done; tied 0 without the macro
eng_start  out  1  one-cycle start pulse to the engine
eng_x1, eng_x2, eng_y1, eng_y2, eng_x  out  S each  latched operand registers
eng_y  in  S  engine result
eng_done  in  1  engine done; level or pulse, edge-detected internally

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt, done, y, err, eng_start and all operand registers = 0; busy=0; round-robin pointer = N-1, so requester 0 has first priority. Reset mid-operation aborts the transaction: no done pulse, no eng_start. The engine is assumed reset by the same rst_n.
- Edge detect: done_q <= eng_done every cycle. A completion is eng_done & ~done_q observed in WAIT. A stale level-high eng_done from a previous op never completes a new op.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if |req, pick the first asserted req[i] searching ptr+1, ptr+2, … modulo N. Latch that requester's five operands into eng_* registers, set gnt=onehot(i), ptr<=i, go to ISSUE. If req==0, stay in IDLE.
  - ISSUE: eng_start=1 for exactly this cycle; go to WAIT.
  - WAIT: on completion, y<=eng_y, go to RESP. Otherwise stay.
  - RESP: done[i]=1 for exactly this cycle (registered output); y is valid; go to IDLE, with gnt cleared on entry to IDLE.
- Latency: req sampled in IDLE at cycle k → eng_start high at k+1 → engine done edge at cycle e → y updated and done pulse at e+1. Next arbitration at e+2.
- Requester rules:
  - A requester holds req and its operands until its done pulse.
  - Operands are latched at grant; later operand changes have no effect on the operation in flight.
  - req dropped while granted is ignored; the operation completes and done is still pulsed.
  - Re-asserted req after done competes normally.
- Fairness: a requester that has just been served has lowest priority next round. With all N requesting, grants rotate 0,1,…,N-1,0.
- Simultaneous requests in the same cycle are resolved only by the pointer order above.
- y holds its last value until the next completion; it is never cleared except by reset.
- eng_start is never asserted outside ISSUE; only one engine operation is outstanding at a time.

Optional Feature:
- Macro LERP_ARB_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no completion: y<=32'h7FC00000 (quiet NaN), err<=1, go to RESP. The done pulse proceeds normally.
  - err is held until the next acceptance in IDLE.
  - A late eng_done edge arriving after the timeout is ignored, because it is not in WAIT.
- Not defined: no counter; WAIT waits indefinitely; err is constant 0.

Test Plan (engine model: fixed 5-cycle latency, computes y1+(x-x1)*(y2-y1)/(x2-x1)):
- Single request: req=4'b0001, x1=0x00000000, x2=0x40000000, y1=0x3F800000, y2=0x40400000, x=0x3F800000 → eng_start one cycle after req; done[0] pulse; y=0x40000000; gnt=0001 throughout.
- Round-robin: req=4'b1111 held, distinct operands per requester → done pulses in order 0,1,2,3,0, each with the correct y. Exactly one eng_start per operation.
- Operand isolation: change req_x for requester 2 one cycle after its grant → y reflects the originally latched operands.
- Stale done: engine model holds eng_done high after finishing; issue a back-to-back request → the second op completes only on a fresh rising edge, and y is correct.
- Reset mid-WAIT: assert rst_n=0 for 1 cycle during WAIT → gnt, done, busy, y = 0 immediately; no done pulse. The next request is served by requester 0 first.
- With LERP_ARB_TIMEOUT_EN and TIMEOUT=8: engine never asserts done → done pulse after 8 WAIT cycles with y=0x7FC00000, err=1. The next accepted request clears err.
